// File: rtl/apb_req_master.sv
// apb_req_master: turns a simple req/gnt request port into single APB
// transfers and returns a one-cycle response pulse with read data and error.
// One transfer is in flight at a time; a stuck completer is cut off after
// TIMEOUT wait cycles (TIMEOUT = 0 waits forever).
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT        = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  // Wide enough to hold TIMEOUT, never narrower than one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The abort fires on the wait edge that would take the count to TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done;
  logic             timeout_hit;

  // Next-state logic plus the APB phase strobes and the request grant.
  always_comb begin
    state_d     = state_q;
    gnt_o       = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    done        = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) state_d = SETUP;
      end
      SETUP: begin
        PSEL    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops PSEL/PENABLE immediately through the decode.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the request on grant; the values then hold through the transfer and idle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else if (gnt_o) begin
      PADDR  <= addr_i;
      PWRITE <= we_i;
      PWDATA <= wdata_i;
    end
  end

  // Wait-state counter: cleared while entering ACCESS, saturates instead of wrapping.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !PREADY && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Response pulse; data and error persist until the next completion or abort.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= done | timeout_hit;
      if (done) begin
        rdata_o <= PWRITE ? 32'd0 : PRDATA;
        err_o   <= PSLVERR;
      end else if (timeout_hit) begin
        rdata_o <= 32'd0;
        err_o   <= 1'b1;
      end
    end
  end

endmodule
